fpmac_arb: RTL and testbench
============================

FPMAC_ARB -- requirements
Module: fpmac_arb

Interface
REQ-001 SHALL have parameter LAT, default 11, equal to the pipeline depth in cycles of the attached fpmac, from operand-register output to mac_out.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port cfg_fixed_pri, input, 1 bit: 1 = fixed priority with requester 0 highest; 0 = round-robin.
REQ-005 SHALL have port req0_valid, input, 1 bit: requester 0 has an operation pending.
REQ-006 SHALL have port req0_in / req0_weight / req0_acc, input, 16 bits each: requester 0 FP16 operands.
REQ-007 SHALL have port req0_ready, output, 1 bit: requester 0 granted this cycle.
REQ-008 SHALL have port req1_valid, input, 1 bit: requester 1 counterpart of req0_valid.
REQ-009 SHALL have port req1_in / req1_weight / req1_acc, input, 16 bits each: requester 1 FP16 operands.
REQ-010 SHALL have port req1_ready, output, 1 bit: requester 1 granted this cycle.
REQ-011 SHALL have port mac_in / mac_weight / mac_acc, output, 16 bits each: registered operands to the fpmac.
REQ-012 SHALL have port mac_out, input, 16 bits: fpmac result.
REQ-013 SHALL have port mac_overflow, input, 1 bit: fpmac overflow flag.
REQ-014 SHALL have port rsp0_valid / rsp1_valid, output, 1 bit each: result returned to requester 0 / 1.
REQ-015 SHALL have port rsp0_data / rsp1_data, output, 16 bits each: mac_out forwarded to requester 0 / 1.
REQ-016 SHALL have port rsp0_ovf / rsp1_ovf, output, 1 bit each: mac_overflow forwarded to requester 0 / 1.
REQ-017 SHALL have port outstanding, output, 4 bits: number of operations in flight.

Function
REQ-018 Handshake: an operation issues in cycle T iff reqN_valid && reqN_ready in T; reqN_ready is combinational from valid inputs and arbiter state; at most one ready per cycle.
REQ-019 Round-robin: sole valid requester is granted; when both valid, grant the requester not in last_grant; last_grant updates only on issue.
REQ-020 Fixed priority (cfg_fixed_pri=1): requester 0 wins every tie; last_grant still updates on issue; mode change takes effect the same cycle.
REQ-021 Operand stage: on issue in T, mac_in/mac_weight/mac_acc = granted operands from T+1; on non-issue cycles all three = 16'h0000 (bubble).
REQ-022 Tag pipeline: a {valid, id} shift register of depth LAT+1 advances every cycle; bubbles carry valid=0.
REQ-023 Result for an issue in T SHALL appear at T+1+LAT: rspN_valid=1 for exactly one cycle for owner N; other requester rsp_valid=0.
REQ-024 rspN_data/rspN_ovf = mac_out/mac_overflow combinationally, qualified by rspN_valid; SHALL be 0 when rspN_valid=0.
REQ-025 Full throughput: one issue per cycle sustained, no bubbles inserted by the arbiter; no response backpressure exists.
REQ-026 outstanding: +1 on issue, -1 on retire, unchanged when both occur; range 0..LAT+1 (max 12 at default); never wraps.
REQ-027 Simultaneous valid deassertion by an ungranted requester is legal; no state change results.

Reset
REQ-028 While RST=0 at a clock edge: tag pipeline valid bits cleared, operand registers = 0, last_grant = 1 (so requester 0 wins the first tie), outstanding = 0.
REQ-029 req0_ready/req1_ready SHALL be 0 while RST=0; rsp*_valid = 0 from the first edge with RST=0 onward.
REQ-030 Reset mid-operation: all in-flight operations discarded; no rsp_valid for them after RST returns to 1, even if mac_out still carries old data.

Verification (LAT=11, fpmac model attached)
REQ-031 req0 alone issues a=5285, b=A579, acc=6978 in cycle 0 -> mac_* = those values in cycle 1; rsp0_valid=1 with rsp0_data=6977 in cycle 12 only; rsp1_valid stays 0.
REQ-032 Both valid for 4 cycles from reset, cfg_fixed_pri=0 -> grants 0,1,0,1; responses in cycles 12..15 alternate rsp0, rsp1, rsp0, rsp1.
REQ-033 Both valid for 3 cycles, cfg_fixed_pri=1 -> req0_ready=1 all three cycles; req1_ready=0; after req0 drops, req1 granted next cycle.
REQ-034 Continuous req0 issue for 12 cycles -> outstanding climbs 1..12, holds 12 while issue and retire coincide, falls to 0 twelve cycles after the last issue.
REQ-035 Issue 5 ops, assert RST=0 in cycle 6 for one cycle -> outstanding=0, no rsp_valid in cycles 7..20; a new issue in cycle 8 returns in cycle 20.
REQ-036 Bubble check: no valid for 3 cycles -> mac_in/mac_weight/mac_acc = 0000 in those cycles, and no rsp_valid LAT+1 cycles later.

Source files
------------

// File: rtl/fpmac_arb.sv
// Two-requester arbiter in front of a LAT-deep fpmac pipeline: registers the granted
// operands, tracks each issue's owner through a tag shift register, and returns results to that owner.
module fpmac_arb #(
  parameter int LAT = 11
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cfg_fixed_pri,
  input  logic        req0_valid,
  input  logic [15:0] req0_in,
  input  logic [15:0] req0_weight,
  input  logic [15:0] req0_acc,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_in,
  input  logic [15:0] req1_weight,
  input  logic [15:0] req1_acc,
  output logic        req1_ready,
  output logic [15:0] mac_in,
  output logic [15:0] mac_weight,
  output logic [15:0] mac_acc,
  input  logic [15:0] mac_out,
  input  logic        mac_overflow,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_data,
  output logic        rsp0_ovf,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_data,
  output logic        rsp1_ovf,
  output logic [3:0]  outstanding
);

  logic           last_grant;
  logic [LAT:0]   tag_vld;
  logic [LAT:0]   tag_id;
  logic           issue;
  logic           issue_id;
  logic           retire;

  // Requester 0 wins a tie when fixed priority is on or requester 1 was granted last.
  always_comb begin
    req0_ready = RST && req0_valid && (!req1_valid || cfg_fixed_pri || last_grant);
    req1_ready = RST && req1_valid && !req0_ready;
  end

  assign issue    = req0_ready || req1_ready;
  assign issue_id = req1_ready;
  assign retire   = tag_vld[LAT];

  // Stage k of the tag pipe lines up with the fpmac result of an issue k+1 cycles earlier.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      last_grant  <= 1'b1;
      tag_vld     <= '0;
      tag_id      <= '0;
      mac_in      <= 16'h0000;
      mac_weight  <= 16'h0000;
      mac_acc     <= 16'h0000;
      outstanding <= 4'd0;
    end else begin
      if (issue) begin
        last_grant <= issue_id;
      end
      tag_vld <= {tag_vld[LAT-1:0], issue};
      tag_id  <= {tag_id[LAT-1:0], issue_id};
      if (req1_ready) begin
        mac_in     <= req1_in;
        mac_weight <= req1_weight;
        mac_acc    <= req1_acc;
      end else if (req0_ready) begin
        mac_in     <= req0_in;
        mac_weight <= req0_weight;
        mac_acc    <= req0_acc;
      end else begin
        mac_in     <= 16'h0000;
        mac_weight <= 16'h0000;
        mac_acc    <= 16'h0000;
      end
      case ({issue, retire})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_comb begin
    rsp0_valid = retire && !tag_id[LAT];
    rsp1_valid = retire &&  tag_id[LAT];
    rsp0_data  = rsp0_valid ? mac_out : 16'h0000;
    rsp1_data  = rsp1_valid ? mac_out : 16'h0000;
    rsp0_ovf   = rsp0_valid && mac_overflow;
    rsp1_ovf   = rsp1_valid && mac_overflow;
  end

endmodule

// File: tb/tb_fpmac_arb.sv
// Bench for fpmac_arb: a stand-in fpmac delay line, a per-cycle scoreboard monitor and directed scenarios.
module tb_fpmac_arb;
  localparam int LAT = 11;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cfg_fixed_pri;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_in, req0_weight, req0_acc;
  logic [15:0] req1_in, req1_weight, req1_acc;
  logic        req0_ready, req1_ready;
  logic [15:0] mac_in, mac_weight, mac_acc, mac_out;
  logic        mac_overflow;
  logic        rsp0_valid, rsp1_valid, rsp0_ovf, rsp1_ovf;
  logic [15:0] rsp0_data, rsp1_data;
  logic [3:0]  outstanding;

  fpmac_arb #(.LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .cfg_fixed_pri(cfg_fixed_pri),
    .req0_valid(req0_valid), .req0_in(req0_in), .req0_weight(req0_weight), .req0_acc(req0_acc),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_in(req1_in), .req1_weight(req1_weight), .req1_acc(req1_acc),
    .req1_ready(req1_ready),
    .mac_in(mac_in), .mac_weight(mac_weight), .mac_acc(mac_acc),
    .mac_out(mac_out), .mac_overflow(mac_overflow),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ovf(rsp0_ovf),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ovf(rsp1_ovf),
    .outstanding(outstanding)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Stand-in fpmac: arbitrary deterministic function, LAT cycles from registered operands.
  function automatic logic [16:0] mac_fn(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    mac_fn = {^(a & b), (a ^ {b[7:0], b[15:8]}) + c};
  endfunction

  logic [16:0] mpipe [LAT];
  initial for (int i = 0; i < LAT; i++) mpipe[i] = '0;
  always @(posedge CLK) begin
    mpipe[0] <= mac_fn(mac_in, mac_weight, mac_acc);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mac_out      = mpipe[LAT-1][15:0];
  assign mac_overflow = mpipe[LAT-1][16];

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  bit          started = 0;
  logic        tb_lg = 1'b1;
  logic [47:0] exp_mac = '0;

  always @(posedge CLK) cyc++;

  // Scoreboard monitor: runs mid-cycle, when inputs and combinational outputs are stable.
  always @(negedge CLK) begin
    logic  e0, e1;
    exp_t  e;
    logic [16:0] r;
    if (started) begin
      chk("outstanding", {28'd0, outstanding}, sb.size());
      chk("mac_ops", {mac_in, mac_weight, mac_acc}, exp_mac);
      e0 = RST && req0_valid && (!req1_valid || cfg_fixed_pri || tb_lg);
      e1 = RST && req1_valid && !e0;
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      if (rsp0_valid || rsp1_valid) begin
        chk("rsp_onehot", rsp0_valid && rsp1_valid, 1'b0);
        if (sb.size() == 0) begin
          chk("rsp_unexp", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", rsp1_valid, e.id);
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_data", e.id ? rsp1_data : rsp0_data, e.data);
          chk("rsp_ovf", e.id ? rsp1_ovf : rsp0_ovf, e.ovf);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        chk("rsp_missing", 1'b0, 1'b1);
        void'(sb.pop_front());
      end
      if (!rsp0_valid) chk("rsp0_idle", {rsp0_data, rsp0_ovf}, 0);
      if (!rsp1_valid) chk("rsp1_idle", {rsp1_data, rsp1_ovf}, 0);
      exp_mac = '0;
      if (e0 || e1) begin
        e.id = e1;
        exp_mac = e1 ? {req1_in, req1_weight, req1_acc} : {req0_in, req0_weight, req0_acc};
        r = mac_fn(exp_mac[47:32], exp_mac[31:16], exp_mac[15:0]);
        e.data = r[15:0];
        e.ovf = r[16];
        e.due = cyc + 1 + LAT;
        sb.push_back(e);
        tb_lg = e1;
      end
    end
    if (!RST) begin
      sb.delete();
      tb_lg = 1'b1;
      exp_mac = '0;
      started = 1;
    end
  end

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v0, input logic v1);
    req0_valid = v0;
    req1_valid = v1;
    req0_in = 16'($urandom); req0_weight = 16'($urandom); req0_acc = 16'($urandom);
    req1_in = 16'($urandom); req1_weight = 16'($urandom); req1_acc = 16'($urandom);
  endtask

  task automatic do_reset();
    drive(0, 0);
    RST = 1'b0;
    next();
    RST = 1'b1;
  endtask

  task automatic idle(input int n);
    drive(0, 0);
    repeat (n) next();
  endtask

  initial begin
    RST = 1'b0;
    cfg_fixed_pri = 1'b0;
    drive(0, 0);
    next();
    @(negedge CLK);
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
    next();
    @(negedge CLK);
    chk("rst_outstanding", outstanding, 4'd0);
    chk("rst_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
    next();
    RST = 1'b1;

    // Single issue from requester 0.
    drive(1, 0);
    req0_in = 16'h5285; req0_weight = 16'hA579; req0_acc = 16'h6978;
    @(negedge CLK);
    chk("single_rdy", {req0_ready, req1_ready}, 2'b10);
    next();
    drive(0, 0);
    @(negedge CLK);
    chk("single_mac", {mac_in, mac_weight, mac_acc}, 48'h5285_A579_6978);
    next();
    for (int i = 2; i <= 13; i++) begin
      @(negedge CLK);
      chk("single_rsp", {rsp0_valid, rsp1_valid}, (i == 12) ? 2'b10 : 2'b00);
      next();
    end

    // Round-robin from reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1);
      @(negedge CLK);
      chk("rr_grant", {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      next();
    end
    idle(8);
    for (int i = 12; i < 16; i++) begin
      @(negedge CLK);
      chk("rr_rsp", {rsp0_valid, rsp1_valid}, (i % 2 == 0) ? 2'b10 : 2'b01);
      next();
    end
    idle(2);

    // Fixed priority, then requester 1 alone, then a same-cycle mode switch.
    do_reset();
    cfg_fixed_pri = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1);
      @(negedge CLK);
      chk("fix_grant", {req0_ready, req1_ready}, 2'b10);
      next();
    end
    drive(0, 1);
    @(negedge CLK);
    chk("fix_req1", {req0_ready, req1_ready}, 2'b01);
    next();
    cfg_fixed_pri = 1'b0;
    drive(1, 1);
    @(negedge CLK);
    chk("rr_after_1", {req0_ready, req1_ready}, 2'b10);
    next();
    cfg_fixed_pri = 1'b1;
    drive(1, 1);
    @(negedge CLK);
    chk("mode_switch", {req0_ready, req1_ready}, 2'b10);
    next();
    cfg_fixed_pri = 1'b0;
    idle(LAT + 3);

    // Sustained issue: occupancy saturates at LAT+1 and drains.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0);
      @(negedge CLK);
      chk("stream_out", outstanding, (i < 12) ? i : 12);
      next();
    end
    drive(0, 0);
    for (int i = 16; i <= 28; i++) begin
      @(negedge CLK);
      if (i == 27) chk("drain_one", outstanding, 4'd1);
      if (i == 28) chk("drain_zero", outstanding, 4'd0);
      next();
    end

    // Reset in the middle of in-flight work.
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      RST = (i != 6);
      drive(i < 5, i == 8);
      @(negedge CLK);
      if (i == 7) chk("midrst_out", outstanding, 4'd0);
      if (i >= 7 && i < 20) chk("midrst_quiet", {rsp0_valid, rsp1_valid}, 2'b00);
      if (i == 20) chk("midrst_new", {rsp0_valid, rsp1_valid}, 2'b01);
      next();
    end
    RST = 1'b1;

    // Bubbles with garbage operands on the idle inputs.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0);
      @(negedge CLK);
      if (i > 0) chk("bubble_mac", {mac_in, mac_weight, mac_acc}, 48'h0);
      next();
    end
    idle(LAT + 2);

    // Random traffic and mode flips.
    for (int i = 0; i < 300; i++) begin
      cfg_fixed_pri = 1'($urandom);
      drive(1'($urandom), 1'($urandom));
      next();
    end
    idle(LAT + 4);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
